// File: rtl/reset_sequencer_if.sv
// Lock input and reset outputs of reset_sequencer, grouped for connection.
// The master side is the sequencer; the slave side is the clock environment and its consumers.
interface reset_sequencer_if;
    logic       i_mmcm_locked;
    logic       o_rst_mhz;
    logic       o_rst_done;
    logic [1:0] o_state;

    modport master (
        input  i_mmcm_locked,
        output o_rst_mhz,
        output o_rst_done,
        output o_state
    );

    modport slave (
        output i_mmcm_locked,
        input  o_rst_mhz,
        input  o_rst_done,
        input  o_state
    );
endinterface

// File: rtl/reset_sequencer.sv
// Source-clock reset sequencer: synchronizes board reset and MMCM lock, filters lock,
// holds reset for a minimum period, then releases o_rst_mhz synchronously.
module reset_sequencer #(
    parameter int unsigned par_sync_stages = 2,
    parameter int unsigned par_lock_filter = 8,
    parameter int unsigned par_hold_cycles = 16
) (
    input  logic               i_clk_mhz,
    input  logic               i_rstn_mhz,
    reset_sequencer_if.master  io_seq
);

    typedef enum logic [1:0] {
        StWaitLock = 2'd0,
        StFilter   = 2'd1,
        StHold     = 2'd2,
        StRun      = 2'd3
    } state_e;

    localparam int unsigned CntMax =
        (par_lock_filter > par_hold_cycles) ? par_lock_filter : par_hold_cycles;
    localparam int unsigned CntW = $clog2(CntMax) + 1;

    logic [par_sync_stages-1:0] r_rstn_sync;
    logic [par_sync_stages-1:0] r_lock_sync;
    state_e                     r_state;
    state_e                     w_state_next;
    logic [CntW-1:0]            r_cnt;
    logic [CntW-1:0]            w_cnt_next;
    logic                       r_rst;
    logic                       r_done;
    logic                       w_rst_next;
    logic                       w_done_next;
    logic                       w_rstn_sync;
    logic                       w_lock_sync;
    logic                       w_filter_done;
    logic                       w_hold_done;

    // Both chains clear on board reset so a stale lock cannot skip the filter.
    always_ff @(posedge i_clk_mhz or negedge i_rstn_mhz) begin
        if (!i_rstn_mhz) begin
            r_rstn_sync <= '0;
            r_lock_sync <= '0;
        end else begin
            r_rstn_sync <= {r_rstn_sync[par_sync_stages-2:0], 1'b1};
            r_lock_sync <= {r_lock_sync[par_sync_stages-2:0], io_seq.i_mmcm_locked};
        end
    end

    assign w_rstn_sync   = r_rstn_sync[par_sync_stages-1];
    assign w_lock_sync   = r_lock_sync[par_sync_stages-1];
    assign w_filter_done = (r_cnt == CntW'(par_lock_filter - 1));
    assign w_hold_done   = (r_cnt == CntW'(par_hold_cycles - 1));

    always_ff @(posedge i_clk_mhz or negedge i_rstn_mhz) begin
        if (!i_rstn_mhz) begin
            r_state <= StWaitLock;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            StWaitLock: begin
                if (w_rstn_sync && w_lock_sync) begin
                    w_state_next = StFilter;
                    w_cnt_next   = '0;
                end
            end
            StFilter: begin
                if (!w_lock_sync) begin
                    w_state_next = StWaitLock;
                    w_cnt_next   = '0;
                end else if (w_filter_done) begin
                    w_state_next = StHold;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + CntW'(1);
                end
            end
            StHold: begin
                if (!w_lock_sync) begin
                    w_state_next = StWaitLock;
                    w_cnt_next   = '0;
                end else if (w_hold_done) begin
                    w_state_next = StRun;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + CntW'(1);
                end
            end
            StRun: begin
                if (!w_lock_sync) begin
                    w_state_next = StWaitLock;
                    w_cnt_next   = '0;
                end
            end
            default: begin
                w_state_next = StWaitLock;
                w_cnt_next   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they change on the same edge as r_state.
    always_comb begin
        w_rst_next  = (w_state_next != StRun);
        w_done_next = (r_state == StHold) && (w_state_next == StRun);
    end

    always_ff @(posedge i_clk_mhz or negedge i_rstn_mhz) begin
        if (!i_rstn_mhz) begin
            r_rst  <= 1'b1;
            r_done <= 1'b0;
        end else begin
            r_rst  <= w_rst_next;
            r_done <= w_done_next;
        end
    end

    assign io_seq.o_rst_mhz  = r_rst;
    assign io_seq.o_rst_done = r_done;
    assign io_seq.o_state    = r_state;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: stimulus queues expected output changes with their
// cycle numbers; a negedge monitor pops and compares on every observed output change.
module tb_reset_sequencer;

    typedef struct {
        int         cyc;
        logic [3:0] val;   // {state, rst, done}
    } evt_t;

    logic clk = 1'b0;
    logic rstn0 = 1'b1;
    logic rstn1 = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    evt_t q0[$];
    evt_t q1[$];
    logic [3:0] prev0 = {2'd0, 1'b1, 1'b0};
    logic [3:0] prev1 = {2'd0, 1'b1, 1'b0};

    reset_sequencer_if if0 ();
    reset_sequencer_if if1 ();

    reset_sequencer dut0 (
        .i_clk_mhz  (clk),
        .i_rstn_mhz (rstn0),
        .io_seq     (if0.master)
    );

    reset_sequencer #(
        .par_sync_stages (3),
        .par_lock_filter (1),
        .par_hold_cycles (1)
    ) dut1 (
        .i_clk_mhz  (clk),
        .i_rstn_mhz (rstn1),
        .io_seq     (if1.master)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int which, input int c, input logic [1:0] st, input logic rst,
                        input logic done);
        evt_t e;
        e.cyc = c;
        e.val = {st, rst, done};
        if (which == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    // Filter entry, hold entry, release with done pulse, then done drop; edges counted from base.
    task automatic push_seq(input int which, input int base, input int s, input int f,
                            input int h);
        push(which, base + s + 1, 2'd1, 1'b1, 1'b0);
        push(which, base + s + 1 + f, 2'd2, 1'b1, 1'b0);
        push(which, base + s + 1 + f + h, 2'd3, 1'b0, 1'b1);
        push(which, base + s + 2 + f + h, 2'd3, 1'b0, 1'b0);
    endtask

    task automatic evt_check(input int which, input logic [3:0] cur);
        evt_t e;
        bit   empty;
        n_checks++;
        empty = (which == 0) ? (q0.size() == 0) : (q1.size() == 0);
        if (empty) begin
            n_errors++;
            $display("FAIL dut%0d_unexpected_change: got state=%0d rst=%0b done=%0b at cycle %0d, required no change",
                     which, cur[3:2], cur[1], cur[0], cyc);
        end else begin
            if (which == 0) e = q0.pop_front();
            else e = q1.pop_front();
            if (e.cyc != cyc || e.val !== cur) begin
                n_errors++;
                $display("FAIL dut%0d_event: got state=%0d rst=%0b done=%0b at cycle %0d, required state=%0d rst=%0b done=%0b at cycle %0d",
                         which, cur[3:2], cur[1], cur[0], cyc,
                         e.val[3:2], e.val[1], e.val[0], e.cyc);
            end
        end
    endtask

    always @(negedge clk) begin
        logic [3:0] cur0;
        logic [3:0] cur1;
        cur0 = {if0.o_state, if0.o_rst_mhz, if0.o_rst_done};
        cur1 = {if1.o_state, if1.o_rst_mhz, if1.o_rst_done};
        if (cur0 !== prev0) begin
            evt_check(0, cur0);
            prev0 = cur0;
        end
        if (cur1 !== prev1) begin
            evt_check(1, cur1);
            prev1 = cur1;
        end
    end

    // Advance to 2 time units after the negedge that follows posedge number c.
    task automatic go(input int c);
        while (cyc < c) @(negedge clk);
        #2;
    endtask

    initial begin
        int b;
        if0.i_mmcm_locked = 1'b1;
        if1.i_mmcm_locked = 1'b1;
        #1;
        rstn0 = 1'b0;
        rstn1 = 1'b0;

        go(3);
        chk("reset_rst", int'(if0.o_rst_mhz), 1);
        chk("reset_done", int'(if0.o_rst_done), 0);
        chk("reset_state", int'(if0.o_state), 0);
        chk("reset_rst_dut1", int'(if1.o_rst_mhz), 1);

        // Locked already high at release: release at edge 27.
        b = cyc;
        rstn0 = 1'b1;
        push_seq(0, b, 2, 8, 16);
        go(b + 32);
        chk("run_rst_low", int'(if0.o_rst_mhz), 0);

        // Lock loss in run: reset back after 3 edges, then full re-release.
        b = cyc;
        if0.i_mmcm_locked = 1'b0;
        push(0, b + 3, 2'd0, 1'b1, 1'b0);
        go(b + 5);
        b = cyc;
        if0.i_mmcm_locked = 1'b1;
        push_seq(0, b, 2, 8, 16);
        go(b + 32);

        // Board reset with lock low, lock arrives 40 cycles after release.
        b = cyc;
        rstn0 = 1'b0;
        if0.i_mmcm_locked = 1'b0;
        #1;
        chk("async_rst_run", int'(if0.o_rst_mhz), 1);
        chk("async_state_run", int'(if0.o_state), 0);
        push(0, b + 1, 2'd0, 1'b1, 1'b0);
        go(b + 3);
        rstn0 = 1'b1;
        go(b + 43);
        b = cyc;
        if0.i_mmcm_locked = 1'b1;
        push_seq(0, b, 2, 8, 16);
        go(b + 32);

        // Lock drop for 3 cycles while filtering at cnt = 5.
        b = cyc;
        if0.i_mmcm_locked = 1'b0;
        push(0, b + 3, 2'd0, 1'b1, 1'b0);
        go(b + 6);
        b = cyc;
        if0.i_mmcm_locked = 1'b1;
        push(0, b + 3, 2'd1, 1'b1, 1'b0);
        go(b + 8);
        chk("filter_state", int'(if0.o_state), 1);
        b = cyc;
        if0.i_mmcm_locked = 1'b0;
        push(0, b + 3, 2'd0, 1'b1, 1'b0);
        go(b + 3);
        b = cyc;
        if0.i_mmcm_locked = 1'b1;
        push_seq(0, b, 2, 8, 16);

        // Board reset between edges while in hold.
        go(b + 15);
        chk("hold_state", int'(if0.o_state), 2);
        b = cyc;
        rstn0 = 1'b0;
        #1;
        chk("async_rst_hold", int'(if0.o_rst_mhz), 1);
        chk("async_state_hold", int'(if0.o_state), 0);
        push(0, b + 1, 2'd0, 1'b1, 1'b0);
        // Drop the remaining events of the aborted sequence.
        q0.delete();
        push(0, b + 1, 2'd0, 1'b1, 1'b0);
        go(b + 3);
        b = cyc;
        rstn0 = 1'b1;
        push_seq(0, b, 2, 8, 16);
        go(b + 32);

        // S = 3, F = 1, H = 1: release at edge 6.
        b = cyc;
        rstn1 = 1'b1;
        push_seq(1, b, 3, 1, 1);
        go(b + 10);
        chk("dut1_run_rst_low", int'(if1.o_rst_mhz), 0);

        chk("dut0_pending_events", q0.size(), 0);
        chk("dut1_pending_events", q1.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Power-on and lock-loss reset sequencer for the source-clock domain. It combines the asynchronous active-low board reset with the asynchronous MMCM `locked` indication. It produces a clean, synchronously released, active-high reset that drives the clock divider's `i_rst_mhz` input and every other `i_clk_mhz` consumer. Release is gated by a lock-stability filter followed by a minimum reset hold period.

## Interface
- `par_sync_stages`, default 2: synchronizer depth for reset release and for `locked`. Legal range ≥ 2.
- `par_lock_filter`, default 8: consecutive synchronized-high `locked` cycles required before the hold period starts. Legal range ≥ 1.
- `par_hold_cycles`, default 16: cycles that `o_rst_mhz` is held after the filter passes. Legal range ≥ 1.
- `i_clk_mhz`  input  1  source clock (MMCM output).
- `i_rstn_mhz`  input  1  one clock; reset is asynchronous and active-low. Clears all state immediately.
- `i_mmcm_locked`  input  1  asynchronous MMCM lock indication.
- `o_rst_mhz`  output  1  synchronous active-high reset to the downstream source-clock logic.
- `o_rst_done`  output  1  one-cycle pulse on the edge where `o_rst_mhz` deasserts.
- `o_state`  output  2  current FSM state encoding, for debug/ILA.

## Operation
- Reset values while `i_rstn_mhz` = 0:
  - `o_rst_mhz` = 1, asserted asynchronously.
  - `o_rst_done` = 0, `o_state` = `ST_WAIT_LOCK` (0).
  - Both synchronizer chains = 0, counter = 0.
- Release synchronizer: a `par_sync_stages` shift register shifts in 1 after `i_rstn_mhz` rises. Its last stage is `s_rstn_sync`.
- Lock synchronizer: a `par_sync_stages` flop chain on `i_mmcm_locked`, reset to 0. Its last stage is `s_lock_sync`.
- Counter: a single shared counter, width `$clog2(max(par_lock_filter, par_hold_cycles))` + 1. It is cleared on every state change.
- FSM states:
  - `ST_WAIT_LOCK` (0): when `s_rstn_sync` && `s_lock_sync`, go to `ST_FILTER` with cnt = 0.
  - `ST_FILTER` (1):
    - `s_lock_sync` = 0: go to `ST_WAIT_LOCK`.
    - else cnt == `par_lock_filter` − 1: go to `ST_HOLD` with cnt = 0.
    - else cnt++.
  - `ST_HOLD` (2):
    - `s_lock_sync` = 0: go to `ST_WAIT_LOCK`.
    - else cnt == `par_hold_cycles` − 1: go to `ST_RUN`.
    - else cnt++.
  - `ST_RUN` (3): `s_lock_sync` = 0 goes to `ST_WAIT_LOCK`. Otherwise stay in `ST_RUN`.
- `o_rst_mhz` is registered from the next state: it is 0 only while the next state is `ST_RUN`. It deasserts on the same edge that enters `ST_RUN` and reasserts on the same edge that leaves it.
- `o_rst_done` is registered and is 1 for exactly the cycle following the `ST_HOLD`→`ST_RUN` edge.
- Lock loss at any point restarts the whole filter and hold sequence. The hold is never shortened.
- A `locked` glitch shorter than one clock period may be missed by the synchronizer; this is acceptable. Any glitch that is captured restarts the sequence.
- Asynchronous reset mid-sequence, in any state: outputs return to their reset values immediately. After release, the sequence starts over from `ST_WAIT_LOCK`.

## Timing
- Edge 1 is the first `i_clk_mhz` rising edge after `i_rstn_mhz` rises. `i_mmcm_locked` is already stable high.
- S = `par_sync_stages`, F = `par_lock_filter`, H = `par_hold_cycles`.
- Enter `ST_FILTER` at edge S+1; enter `ST_HOLD` at edge S+1+F.
- `o_rst_mhz` falls and `ST_RUN` is entered at edge S+1+F+H. With the defaults this is edge 27. `o_rst_done` is high for exactly the cycle after edge 27.
- If `locked` rises later than `i_rstn_mhz`, count the same intervals from the first edge that samples `locked` high.
- Lock loss in `ST_RUN`: `o_rst_mhz` rises at the (S+1)th edge after `i_mmcm_locked` falls, i.e. 3 edges with defaults.
- Reset assertion has zero clock latency. Reset deassertion is always synchronous to `i_clk_mhz`.

## Test plan
- Locked high, release `i_rstn_mhz` (defaults) -> `o_rst_mhz` = 1 through edge 26 and falls at edge 27. `o_rst_done` is a single pulse after edge 27. `o_state` follows 0,1,2,3.
- `locked` rises 40 cycles after reset release -> `o_rst_mhz` falls 27 edges after the first edge that samples `locked` high.
- `locked` dropped for 3 cycles while in `ST_FILTER` at cnt = 5 -> returns to `ST_WAIT_LOCK`. The full F+H sequence restarts once `locked` returns high. No `o_rst_done` pulse occurs during the drop.
- `locked` dropped while in `ST_RUN` -> `o_rst_mhz` = 1 at the 3rd edge. After `locked` returns, re-release takes S+1+F+H edges and produces a second `o_rst_done` pulse.
- Assert `i_rstn_mhz` = 0 mid-`ST_HOLD`, between clock edges -> `o_rst_mhz` = 1 before the next edge, `o_state` = 0, and the sequence restarts on release.
- Parameters S = 3, F = 1, H = 1 -> `o_rst_mhz` falls at edge 6.
